// File: rtl/eth_pkg.sv
// Shared Ethernet constants, CRC-32 FSM state type and the reflected byte-update function.
package eth_pkg;

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  // One byte through the reflected CRC, bit 0 of the byte first.
  function automatic logic [CRC_W-1:0] crc32_byte_upd(
    input logic [CRC_W-1:0]  crc,
    input logic [BYTE_W-1:0] data,
    input logic [CRC_W-1:0]  poly
  );
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? poly : CRC_W'(0));
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-serial IEEE 802.3 FCS generator for the MII TX path.
// Optional CRC32_RESIDUE_EN adds crc_ok (good-frame residue check for RX reuse).
module eth_crc32
  import eth_pkg::*;
#(
  parameter logic [31:0] P_POLY   = CRC32_POLY_REFL,
  parameter logic [31:0] P_INIT   = CRC32_INIT,
  parameter logic [31:0] P_XOROUT = CRC32_XOROUT
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  input  logic        sof,
  input  logic        eof,
  output logic [31:0] crc_out,
  output logic        crc_done
`ifdef CRC32_RESIDUE_EN
  ,
  output logic        crc_ok
`endif
);

  crc_state_t  state, state_nxt;
  logic [31:0] crc_reg, crc_reg_nxt;
  logic [31:0] crc_out_nxt;
  logic        crc_done_nxt;
`ifdef CRC32_RESIDUE_EN
  logic        crc_ok_nxt;
`endif

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_reg  <= P_INIT;
      crc_out  <= 32'h0;
      crc_done <= 1'b0;
`ifdef CRC32_RESIDUE_EN
      crc_ok   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      crc_reg  <= crc_reg_nxt;
      crc_out  <= crc_out_nxt;
      crc_done <= crc_done_nxt;
`ifdef CRC32_RESIDUE_EN
      crc_ok   <= crc_ok_nxt;
`endif
    end
  end

  // Next-state and next-output logic; eof wins over crc_en while running.
  always_comb begin
    state_nxt    = state;
    crc_reg_nxt  = crc_reg;
    crc_out_nxt  = crc_out;
    crc_done_nxt = 1'b0;
`ifdef CRC32_RESIDUE_EN
    crc_ok_nxt   = crc_ok;
`endif
    case (state)
      IDLE: begin
        if (crc_en && sof) begin
          crc_reg_nxt = crc32_byte_upd(P_INIT, data_in, P_POLY);
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (eof) begin
          crc_out_nxt  = crc_reg ^ P_XOROUT;
          crc_done_nxt = 1'b1;
          state_nxt    = DONE;
`ifdef CRC32_RESIDUE_EN
          crc_ok_nxt   = (crc_reg == CRC32_RESIDUE);
`endif
        end else if (crc_en) begin
          crc_reg_nxt = crc32_byte_upd(crc_reg, data_in, P_POLY);
        end
      end
      DONE: begin
        if (!eof) begin
          crc_reg_nxt = P_INIT;
          state_nxt   = IDLE;
        end
      end
      default: begin
        crc_reg_nxt = P_INIT;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_crc32.sv
// Self-checking bench for eth_crc32: scoreboard of expected FCS values from an MSB-first model.
// Define CRC32_RESIDUE_EN to also exercise crc_ok.
module tb_eth_crc32;

  logic        tx_clk;
  logic        rst_n;
  logic        crc_en;
  logic [7:0]  data_in;
  logic        sof;
  logic        eof;
  logic [31:0] crc_out;
  logic        crc_done;
`ifdef CRC32_RESIDUE_EN
  logic        crc_ok;
`endif

  int          n_assert;
  int          n_fail;
  logic [31:0] sb[$];

  eth_crc32 dut (
    .tx_clk   (tx_clk),
    .rst_n    (rst_n),
    .crc_en   (crc_en),
    .data_in  (data_in),
    .sof      (sof),
    .eof      (eof),
    .crc_out  (crc_out),
    .crc_done (crc_done)
`ifdef CRC32_RESIDUE_EN
    ,
    .crc_ok   (crc_ok)
`endif
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // Non-reflected MSB-first CRC over bit-reversed bytes, output reflected.
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] r;
    logic [31:0] o;
    logic        fb;
    r = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[31] ^ q[k][i];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return o ^ 32'hFFFFFFFF;
  endfunction

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic drive_bytes(input logic [7:0] q[$], input int gap, input int sof_len);
    for (int k = 0; k < q.size(); k++) begin
      crc_en  = 1'b1;
      data_in = q[k];
      sof     = (k < sof_len);
      tick();
      if (gap > 0) begin
        crc_en  = 1'b0;
        data_in = 8'h00;
        repeat (gap) tick();
      end
    end
    crc_en  = 1'b0;
    sof     = 1'b0;
    data_in = 8'h00;
  endtask

  // Raise eof, check done latency and FCS, hold eof, then release.
  task automatic finish_frame(input string name, input int hold);
    logic [31:0] exp_crc;
    logic [31:0] first;
    int          lat;
    int          extra;
    int          moved;
    eof = 1'b1;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      tick();
      if (crc_done) lat = c;
    end
    n_assert++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL %s_latency: crc_done after %0d cycles, required 1", name, lat);
    end
    exp_crc = sb.pop_front();
    n_assert++;
    if (crc_out !== exp_crc) begin
      n_fail++;
      $display("FAIL %s_crc: got %h, required %h", name, crc_out, exp_crc);
    end
    first = crc_out;
    extra = 0;
    moved = 0;
    repeat (hold) begin
      tick();
      if (crc_done !== 1'b0) extra++;
      if (crc_out !== first) moved++;
    end
    n_assert++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL %s_single_pulse: %0d extra crc_done cycles, required 0", name, extra);
    end
    n_assert++;
    if (moved != 0) begin
      n_fail++;
      $display("FAIL %s_hold: crc_out changed in %0d cycles, required 0", name, moved);
    end
    eof = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int gap, input int sof_len,
                           input int hold, input string name);
    sb.push_back(ref_crc(q));
    drive_bytes(q, gap, sof_len);
    finish_frame(name, hold);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    crc_en  = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
    data_in = 8'h00;
    repeat (3) tick();
    n_assert++;
    if (crc_out !== 32'h0 || crc_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: crc_out=%h crc_done=%b, required 00000000/0", crc_out, crc_done);
    end
`ifdef CRC32_RESIDUE_EN
    n_assert++;
    if (crc_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_crc_ok: got %b, required 0", crc_ok);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_check_string();
    logic [7:0] q[$];
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    n_assert++;
    if (ref_crc(q) !== 32'hCBF43926) begin
      n_fail++;
      $display("FAIL model_check: got %h, required cbf43926", ref_crc(q));
    end
    sb.push_back(32'hCBF43926);
    drive_bytes(q, 0, 1);
    finish_frame("check_string", 3);
  endtask

  task automatic test_nibble_paced();
    logic [7:0] q[$];
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    sb.push_back(32'hCBF43926);
    drive_bytes(q, 1, 4);
    finish_frame("nibble_paced", 2);
  endtask

  task automatic test_min_frame();
    logic [7:0] q[$];
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h04, 8'h7B, 8'hCB, 8'h62, 8'hBF, 8'h3E, 8'h08, 8'h00};
    for (int i = 0; i < 46; i++) q.push_back(8'h00);
    run_frame(q, 0, 1, 10, "min_frame");
  endtask

  task automatic test_idle_ignore();
    int pulses;
    pulses = 0;
    eof = 1'b1;
    repeat (3) begin
      tick();
      if (crc_done) pulses++;
    end
    eof    = 1'b0;
    crc_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'hA5 + 8'(i);
      tick();
      if (crc_done) pulses++;
    end
    crc_en  = 1'b0;
    data_in = 8'h00;
    n_assert++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL idle_ignore: %0d crc_done pulses, required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    qa = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    for (int i = 0; i < 20; i++) qb.push_back(8'($urandom_range(0, 255)));
    run_frame(qa, 0, 2, 1, "b2b_a");
    test_idle_ignore();
    run_frame(qb, 0, 1, 1, "b2b_b");
  endtask

  task automatic test_mid_reset();
    logic [7:0] q[$];
    logic [7:0] part[$];
    q    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    part = '{8'h55, 8'h66, 8'h77, 8'h88};
    drive_bytes(part, 0, 1);
    rst_n = 1'b0;
    tick();
    tick();
    n_assert++;
    if (crc_out !== 32'h0 || crc_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: crc_out=%h crc_done=%b, required 00000000/0", crc_out, crc_done);
    end
    rst_n = 1'b1;
    tick();
    sb.push_back(32'hCBF43926);
    drive_bytes(q, 0, 1);
    finish_frame("after_reset", 2);
  endtask

`ifdef CRC32_RESIDUE_EN
  task automatic test_residue();
    logic [7:0] q[$];
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame(q, 0, 1, 2, "residue_good");
    n_assert++;
    if (crc_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL residue_good_ok: got %b, required 1", crc_ok);
    end
    q[2] = q[2] ^ 8'h04;
    run_frame(q, 0, 1, 2, "residue_bad");
    n_assert++;
    if (crc_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL residue_bad_ok: got %b, required 0", crc_ok);
    end
  endtask
`endif

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_check_string();
    test_nibble_paced();
    test_min_frame();
    test_back_to_back();
    test_mid_reset();
`ifdef CRC32_RESIDUE_EN
    test_residue();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
